// File: rtl/wb_mem_arbiter.sv
// Two-master round-robin Wishbone classic arbiter in front of one shared memory slave.
// The grant is held for the owner's whole cycle; a slave that never acks is cut off with a bus error.
module wb_mem_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    sys_clk,
  input  logic                    rst_n,

  input  logic                    m0_cyc,
  input  logic                    m0_stb,
  input  logic                    m0_we,
  input  logic [DATA_WIDTH/8-1:0] m0_wstrb,
  input  logic [ADDR_WIDTH-1:0]   m0_addr,
  input  logic [DATA_WIDTH-1:0]   m0_data_i,
  output logic [DATA_WIDTH-1:0]   m0_data_o,
  output logic                    m0_ack,
  output logic                    m0_err,

  input  logic                    m1_cyc,
  input  logic                    m1_stb,
  input  logic                    m1_we,
  input  logic [DATA_WIDTH/8-1:0] m1_wstrb,
  input  logic [ADDR_WIDTH-1:0]   m1_addr,
  input  logic [DATA_WIDTH-1:0]   m1_data_i,
  output logic [DATA_WIDTH-1:0]   m1_data_o,
  output logic                    m1_ack,
  output logic                    m1_err,

  output logic                    s_cyc,
  output logic                    s_stb,
  output logic                    s_we,
  output logic [DATA_WIDTH/8-1:0] s_wstrb,
  output logic [ADDR_WIDTH-1:0]   s_addr,
  output logic [DATA_WIDTH-1:0]   s_data_o,
  input  logic [DATA_WIDTH-1:0]   s_data_i,
  input  logic                    s_ack,

  output logic [1:0]              grant
);

  localparam int SW    = DATA_WIDTH / 8;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_ERR
  } state_t;

  state_t           state_reg;
  logic             owner_reg;
  logic             last_reg;
  logic [CNT_W-1:0] wait_cnt_reg;

  logic [1:0]            cyc_vec;
  logic [1:0]            stb_vec;
  logic [1:0]            we_vec;
  logic [1:0]            req_vec;
  logic [1:0]            ack_vec;
  logic [1:0]            err_vec;
  logic [SW-1:0]         wstrb_arr [2];
  logic [ADDR_WIDTH-1:0] addr_arr  [2];
  logic [DATA_WIDTH-1:0] wdata_arr [2];

  assign cyc_vec      = {m1_cyc, m0_cyc};
  assign stb_vec      = {m1_stb, m0_stb};
  assign we_vec       = {m1_we, m0_we};
  assign req_vec      = cyc_vec & stb_vec;
  assign wstrb_arr[0] = m0_wstrb;
  assign wstrb_arr[1] = m1_wstrb;
  assign addr_arr[0]  = m0_addr;
  assign addr_arr[1]  = m1_addr;
  assign wdata_arr[0] = m0_data_i;
  assign wdata_arr[1] = m1_data_i;

  logic busy;
  logic owner_cyc;
  logic owner_stb;

  assign busy      = (state_reg == ST_BUSY);
  assign owner_cyc = cyc_vec[owner_reg];
  assign owner_stb = stb_vec[owner_reg];

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      owner_reg    <= 1'b0;
      last_reg     <= 1'b1;
      wait_cnt_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (|req_vec) begin
            // On contention the master that did not own the bus last time wins.
            owner_reg    <= (&req_vec) ? ~last_reg : req_vec[1];
            wait_cnt_reg <= '0;
            state_reg    <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // Release beats ack, and ack beats timeout.
          if (!owner_cyc) begin
            last_reg  <= owner_reg;
            state_reg <= ST_IDLE;
          end else if (s_ack) begin
            wait_cnt_reg <= '0;
          end else if (wait_cnt_reg == CNT_MAX) begin
            state_reg <= ST_ERR;
          end else if (owner_stb) begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
          end
        end
        ST_ERR: begin
          last_reg  <= owner_reg;
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  // The owner's request passes straight through to the slave only while BUSY.
  assign s_cyc    = busy & owner_cyc;
  assign s_stb    = busy & owner_stb;
  assign s_we     = busy & we_vec[owner_reg];
  assign s_wstrb  = busy ? wstrb_arr[owner_reg] : '0;
  assign s_addr   = busy ? addr_arr[owner_reg]  : '0;
  assign s_data_o = busy ? wdata_arr[owner_reg] : '0;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_master
      assign grant[gi]   = (state_reg != ST_IDLE) && (owner_reg == 1'(gi));
      assign ack_vec[gi] = busy && (owner_reg == 1'(gi)) && s_ack;
      assign err_vec[gi] = (state_reg == ST_ERR) && (owner_reg == 1'(gi));
    end
  endgenerate

  assign m0_ack    = ack_vec[0];
  assign m1_ack    = ack_vec[1];
  assign m0_err    = err_vec[0];
  assign m1_err    = err_vec[1];
  assign m0_data_o = s_data_i;
  assign m1_data_o = s_data_i;

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Random two-master traffic against the arbiter, compared every cycle with a
// bus-ownership model built from the arbitration, locking and timeout rules.
module tb_wb_mem_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int SW   = DW / 8;
  localparam int TO   = 4;
  localparam int NCYC = 2500;

  logic          sys_clk = 1'b0;
  logic          rst_n;
  logic          m0_cyc, m0_stb, m0_we, m0_ack, m0_err;
  logic          m1_cyc, m1_stb, m1_we, m1_ack, m1_err;
  logic [SW-1:0] m0_wstrb, m1_wstrb, s_wstrb;
  logic [AW-1:0] m0_addr, m1_addr, s_addr;
  logic [DW-1:0] m0_data_i, m1_data_i, m0_data_o, m1_data_o;
  logic          s_cyc, s_stb, s_we, s_ack;
  logic [DW-1:0] s_data_o, s_data_i;
  logic [1:0]    grant;

  always #5 sys_clk = ~sys_clk;

  wb_mem_arbiter #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .sys_clk  (sys_clk),
    .rst_n    (rst_n),
    .m0_cyc   (m0_cyc),
    .m0_stb   (m0_stb),
    .m0_we    (m0_we),
    .m0_wstrb (m0_wstrb),
    .m0_addr  (m0_addr),
    .m0_data_i(m0_data_i),
    .m0_data_o(m0_data_o),
    .m0_ack   (m0_ack),
    .m0_err   (m0_err),
    .m1_cyc   (m1_cyc),
    .m1_stb   (m1_stb),
    .m1_we    (m1_we),
    .m1_wstrb (m1_wstrb),
    .m1_addr  (m1_addr),
    .m1_data_i(m1_data_i),
    .m1_data_o(m1_data_o),
    .m1_ack   (m1_ack),
    .m1_err   (m1_err),
    .s_cyc    (s_cyc),
    .s_stb    (s_stb),
    .s_we     (s_we),
    .s_wstrb  (s_wstrb),
    .s_addr   (s_addr),
    .s_data_o (s_data_o),
    .s_data_i (s_data_i),
    .s_ack    (s_ack),
    .grant    (grant)
  );

  // Per-master drive state
  logic          mc [2];
  logic          ms [2];
  logic          mw [2];
  logic [SW-1:0] mst[2];
  logic [AW-1:0] ma [2];
  logic [DW-1:0] md [2];
  int            active[2];
  int            beats [2];
  bit            ack_prev[2];
  bit            err_prev[2];

  assign m0_cyc = mc[0];  assign m0_stb = ms[0];  assign m0_we = mw[0];
  assign m0_wstrb = mst[0]; assign m0_addr = ma[0]; assign m0_data_i = md[0];
  assign m1_cyc = mc[1];  assign m1_stb = ms[1];  assign m1_we = mw[1];
  assign m1_wstrb = mst[1]; assign m1_addr = ma[1]; assign m1_data_i = md[1];

  // Model: who holds the bus (-1 = nobody), whether this is the error cycle,
  // who was served last and how long the owner has waited without ack.
  int cur_owner;
  int last_m;
  int waited;
  bit erroring;

  int n_checks = 0;
  int n_errors = 0;
  int n_timeouts = 0;
  int n_contend = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    cur_owner = -1;
    last_m    = 1;
    waited    = 0;
    erroring  = 1'b0;
  endtask

  task automatic new_beat(input int n);
    mw[n]  = 1'($urandom);
    mst[n] = SW'($urandom);
    ma[n]  = $urandom;
    md[n]  = $urandom;
  endtask

  task automatic drive_master(input int n);
    bit at_limit;
    at_limit = (cur_owner == n) && !erroring && (waited == TO);
    if (active[n] == 0) begin
      new_beat(n);
      if ($urandom % 4 == 0) begin
        active[n] = 1;
        beats[n]  = 1 + int'($urandom % 4);
        mc[n] = 1'b1;
        ms[n] = 1'b1;
      end else begin
        mc[n] = 1'b0;
        ms[n] = 1'($urandom % 8 == 0);
      end
    end else if (ack_prev[n]) begin
      beats[n]--;
      if (beats[n] == 0) begin
        active[n] = 0;
        mc[n] = 1'b0;
        ms[n] = 1'b0;
      end else begin
        new_beat(n);
        ms[n] = 1'($urandom % 4 != 0);
      end
    end else if (err_prev[n] || ($urandom % 60 == 0) || (at_limit && $urandom % 3 == 0)) begin
      active[n] = 0;
      mc[n] = 1'b0;
      ms[n] = 1'b0;
    end else if (!ms[n]) begin
      ms[n] = 1'($urandom % 2);
    end
  endtask

  initial begin
    bit         busy;
    int         o;
    logic [1:0] exp_grant;
    bit         exp_ack[2];
    bit         exp_err[2];
    bit         req0, req1;

    rst_n = 1'b0;
    s_ack = 1'b0;
    s_data_i = '0;
    for (int n = 0; n < 2; n++) begin
      mc[n] = 1'b0; ms[n] = 1'b0; mw[n] = 1'b0;
      mst[n] = '0; ma[n] = '0; md[n] = '0;
      active[n] = 0; beats[n] = 0;
      ack_prev[n] = 1'b0; err_prev[n] = 1'b0;
    end
    repeat (2) @(posedge sys_clk);
    model_reset();

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge sys_clk);
      rst_n = (cyc < 3) ? 1'b1 : 1'(($urandom % 200) != 0);
      for (int n = 0; n < 2; n++) drive_master(n);
      if (cur_owner >= 0 && !erroring && waited == TO)
        s_ack = 1'($urandom % 2);
      else
        s_ack = 1'($urandom % ((cyc < 1200) ? 2 : 8) == 0);
      s_data_i = $urandom;
      #1;

      busy = (cur_owner >= 0) && !erroring;
      o    = (cur_owner >= 0) ? cur_owner : 0;
      exp_grant = (cur_owner < 0) ? 2'b00 : ((cur_owner == 0) ? 2'b01 : 2'b10);
      for (int n = 0; n < 2; n++) begin
        exp_ack[n] = busy && (cur_owner == n) && s_ack;
        exp_err[n] = erroring && (cur_owner == n);
      end

      check_val("grant",     64'(grant),     64'(exp_grant));
      check_val("s_cyc",     64'(s_cyc),     64'(busy ? mc[o] : 1'b0));
      check_val("s_stb",     64'(s_stb),     64'(busy ? ms[o] : 1'b0));
      check_val("s_we",      64'(s_we),      64'(busy ? mw[o] : 1'b0));
      check_val("s_wstrb",   64'(s_wstrb),   64'(busy ? mst[o] : SW'(0)));
      check_val("s_addr",    64'(s_addr),    64'(busy ? ma[o] : AW'(0)));
      check_val("s_data_o",  64'(s_data_o),  64'(busy ? md[o] : DW'(0)));
      check_val("m0_ack",    64'(m0_ack),    64'(exp_ack[0]));
      check_val("m1_ack",    64'(m1_ack),    64'(exp_ack[1]));
      check_val("m0_err",    64'(m0_err),    64'(exp_err[0]));
      check_val("m1_err",    64'(m1_err),    64'(exp_err[1]));
      check_val("m0_data_o", 64'(m0_data_o), 64'(s_data_i));
      check_val("m1_data_o", 64'(m1_data_o), 64'(s_data_i));

      for (int n = 0; n < 2; n++) begin
        if (exp_ack[n])
          $display("m%0d ack %s addr=%08h wdata=%08h rdata=%08h", n, mw[n] ? "wr" : "rd",
                   ma[n], md[n], s_data_i);
        if (exp_err[n])
          $display("m%0d bus error after %0d wait cycles", n, TO);
        ack_prev[n] = exp_ack[n];
        err_prev[n] = exp_err[n];
      end

      // Advance the model across the coming rising edge.
      req0 = mc[0] && ms[0];
      req1 = mc[1] && ms[1];
      if (!rst_n) begin
        if (cur_owner >= 0) $display("reset asserted while m%0d owns the bus", cur_owner);
        model_reset();
      end else if (cur_owner < 0) begin
        if (req0 && req1) begin
          cur_owner = (last_m == 0) ? 1 : 0;
          n_contend++;
        end else if (req0) begin
          cur_owner = 0;
        end else if (req1) begin
          cur_owner = 1;
        end
        waited = 0;
      end else if (erroring) begin
        last_m    = cur_owner;
        cur_owner = -1;
        erroring  = 1'b0;
      end else if (!mc[cur_owner]) begin
        last_m    = cur_owner;
        cur_owner = -1;
      end else if (s_ack) begin
        waited = 0;
      end else if (waited == TO) begin
        erroring = 1'b1;
        n_timeouts++;
      end else if (ms[cur_owner]) begin
        waited++;
      end
    end

    $display("coverage: %0d contentions, %0d timeouts", n_contend, n_timeouts);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
